// File: rtl/clk_test.sv
// clk_test: measures the SNES sysclk frequency by counting its rising edges over a fixed gate of clk cycles.
// Latency: the result register updates once per WINDOW_CYCLES+1 clk cycles; the first result follows reset release by the same amount.
// Backpressure: none; free-running measurement with a continuously valid output register (all ones until the first window completes).
module clk_test #(
    parameter int unsigned WINDOW_CYCLES = 96000000,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sysclk,
    output logic [31:0] snes_sysclk_freq
);

    // Gate length as a 32-bit value so comparisons against gate_cnt are width-matched.
    localparam logic [31:0] WINDOW = 32'(WINDOW_CYCLES);

    // Value the output register holds until a real measurement exists.
    localparam logic [31:0] NO_MEASUREMENT = 32'hFFFF_FFFF;

    // Synchronizer chain: bit 0 samples the raw input, bit SYNC_STAGES-1 is the oldest stage.
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Measurement state.
    logic [31:0] gate_cnt_q;
    logic [31:0] gate_cnt_d;
    logic [31:0] edge_cnt_q;
    logic [31:0] edge_cnt_d;
    logic [31:0] freq_q;
    logic [31:0] freq_d;

    // One-cycle pulse per synchronized sysclk rising edge.
    logic edge_stb;

    // Latch cycle: the gate has run its full length this period.
    logic latch_now;

    // Shift raw sysclk into the synchronizer; raw sysclk is only ever sampled by this flop.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sysclk};
    end

    // Rising edge seen between the two oldest stages: newer stage high, older stage still low.
    always_comb begin
        edge_stb = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
    end

    // Count while the gate is open; in the closing cycle publish the total and restart from zero.
    // A strobe landing in the closing cycle is deliberately dropped so each window sees exactly
    // WINDOW_CYCLES counting cycles.
    always_comb begin
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        freq_d     = freq_q;
        latch_now  = (gate_cnt_q >= WINDOW);
        if (!latch_now) begin
            gate_cnt_d = gate_cnt_q + 32'd1;
            if (edge_stb) begin
                // Wraps modulo 2^32; unreachable for any in-range sysclk.
                edge_cnt_d = edge_cnt_q + 32'd1;
            end
        end else begin
            freq_d     = edge_cnt_q;
            gate_cnt_d = '0;
            edge_cnt_d = '0;
        end
    end

    // State registers; reset aborts any partial window and marks the output as not yet measured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            freq_q     <= NO_MEASUREMENT;
        end else begin
            sync_q     <= sync_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            freq_q     <= freq_d;
        end
    end

    assign snes_sysclk_freq = freq_q;

endmodule

// File: tb/tb_clk_test.sv
// tb_clk_test: randomized and directed stimulus for clk_test against a sample-history reference model.
// Latency: compares every clk cycle on the falling edge, after the model has absorbed the rising edge.
// Backpressure: not applicable; sysclk is driven on falling clk edges so every rising-edge sample is unambiguous.
module tb_clk_test;

    localparam int W      = 16;
    localparam int PERIOD = W + 1;

    logic        clk;
    logic        rst;
    logic        sysclk;
    logic [31:0] snes_sysclk_freq;

    clk_test #(
        .WINDOW_CYCLES (W),
        .SYNC_STAGES   (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .sysclk           (sysclk),
        .snes_sysclk_freq (snes_sysclk_freq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference model: samp[k] is the sysclk level seen at the k-th clk edge after reset release
    // (samp[0] stands for the cleared synchronizer). A rise between samples m-1 and m is credited
    // to edge m+1; a latch at edge L reports the rises credited to edges L-W .. L-1.
    bit          samp[$];
    int          n;
    logic [31:0] exp_freq;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            samp.delete();
            samp.push_back(1'b0);
            n        = 0;
            exp_freq = 32'hFFFF_FFFF;
        end else begin
            int c;
            n = n + 1;
            samp.push_back(sysclk);
            if (n % PERIOD == 0) begin
                c = 0;
                for (int m = n - W - 1; m <= n - 2; m++) begin
                    if (m >= 1 && samp[m] && !samp[m-1]) c++;
                end
                exp_freq = 32'(c);
            end
        end
    end

    // Periodic stimulus generator: sysclk spends 'half' clk cycles low, then 'half' high.
    int ph;
    int half;

    task automatic drive_periodic();
        sysclk = ((ph / half) % 2) != 0;
        ph++;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        sysclk = 1'b0;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (snes_sysclk_freq !== 32'hFFFF_FFFF) begin
                miscompares++;
                $display("FAIL reset_hold: got %h expected ffffffff", snes_sysclk_freq);
            end
        end
        half = 2;
        ph   = 0;
        rst  = 1'b0;
        drive_periodic();
        for (int i = 1; i <= PERIOD; i++) begin
            @(negedge clk);
            vectors++;
            if (i < PERIOD) begin
                if (snes_sysclk_freq !== 32'hFFFF_FFFF) begin
                    miscompares++;
                    $display("FAIL first_result_early: cycle %0d got %h expected ffffffff", i, snes_sysclk_freq);
                end
            end else begin
                if (snes_sysclk_freq === 32'hFFFF_FFFF || snes_sysclk_freq !== exp_freq) begin
                    miscompares++;
                    $display("FAIL first_result: cycle %0d got %h expected %h", i, snes_sysclk_freq, exp_freq);
                end
            end
            drive_periodic();
        end
    endtask

    task automatic test_period4();
        half = 2;
        repeat (3 * PERIOD) begin
            @(negedge clk);
            vectors++;
            if (snes_sysclk_freq !== exp_freq) begin
                miscompares++;
                $display("FAIL period4_model: n=%0d got %h expected %h", n, snes_sysclk_freq, exp_freq);
            end
            if (n % PERIOD == 0) begin
                vectors++;
                if (snes_sysclk_freq !== 32'd4) begin
                    miscompares++;
                    $display("FAIL period4_value: n=%0d got %0d expected 4", n, snes_sysclk_freq);
                end
            end
            drive_periodic();
        end
    endtask

    task automatic test_stopped();
        int latches;
        latches = 0;
        sysclk  = 1'b0;
        repeat (2 * PERIOD + 1) begin
            @(negedge clk);
            vectors++;
            if (snes_sysclk_freq !== exp_freq) begin
                miscompares++;
                $display("FAIL stopped_model: n=%0d got %h expected %h", n, snes_sysclk_freq, exp_freq);
            end
            if (n % PERIOD == 0) begin
                latches++;
                if (latches >= 2) begin
                    vectors++;
                    if (snes_sysclk_freq !== 32'd0) begin
                        miscompares++;
                        $display("FAIL stopped_value: n=%0d got %0d expected 0", n, snes_sysclk_freq);
                    end
                end
            end
        end
    endtask

    task automatic test_switch();
        int stage;
        int latches;
        stage   = 0;
        latches = 0;
        half    = 4;
        for (int i = 0; i < 200 && stage < 6; i++) begin
            @(negedge clk);
            vectors++;
            if (snes_sysclk_freq !== exp_freq) begin
                miscompares++;
                $display("FAIL switch_model: n=%0d got %h expected %h", n, snes_sysclk_freq, exp_freq);
            end
            case (stage)
                0: if (n % PERIOD == 0) begin
                    latches++;
                    if (latches == 2) begin
                        vectors++;
                        if (snes_sysclk_freq !== 32'd2) begin
                            miscompares++;
                            $display("FAIL period8_value: got %0d expected 2", snes_sysclk_freq);
                        end
                        stage = 1;
                    end
                end
                1: if (n % PERIOD == PERIOD - 1) begin
                    ph    = 0;
                    stage = 2;
                end
                2: if (n % PERIOD == 0) begin
                    vectors++;
                    if (snes_sysclk_freq !== 32'd2) begin
                        miscompares++;
                        $display("FAIL period8_again: got %0d expected 2", snes_sysclk_freq);
                    end
                    stage = 3;
                end
                3: if (n % PERIOD == 7) begin
                    half  = 2;
                    ph    = 0;
                    stage = 4;
                end
                4: if (n % PERIOD == 0) begin
                    vectors++;
                    if (snes_sysclk_freq !== 32'd2 && snes_sysclk_freq !== 32'd3) begin
                        miscompares++;
                        $display("FAIL mixed_window: got %0d expected 2 or 3", snes_sysclk_freq);
                    end
                    stage = 5;
                end
                5: if (n % PERIOD == 0) begin
                    vectors++;
                    if (snes_sysclk_freq !== 32'd4) begin
                        miscompares++;
                        $display("FAIL after_switch: got %0d expected 4", snes_sysclk_freq);
                    end
                    stage = 6;
                end
                default: ;
            endcase
            drive_periodic();
        end
        vectors++;
        if (stage != 6) begin
            miscompares++;
            $display("FAIL switch_timeout: reached stage %0d expected 6", stage);
        end
    endtask

    task automatic test_latch_edge();
        int stage;
        stage  = 0;
        sysclk = 1'b0;
        for (int i = 0; i < 200 && stage < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (snes_sysclk_freq !== exp_freq) begin
                miscompares++;
                $display("FAIL latch_edge_model: n=%0d got %h expected %h", n, snes_sysclk_freq, exp_freq);
            end
            case (stage)
                0: if (n % PERIOD == 0) stage = 1;
                1: if (n % PERIOD == PERIOD - 2) begin
                    // Sampled at the last counting edge, so its strobe falls in the latch cycle.
                    sysclk = 1'b1;
                    stage  = 2;
                end
                2: if (n % PERIOD == 0) begin
                    vectors++;
                    if (snes_sysclk_freq !== 32'd0) begin
                        miscompares++;
                        $display("FAIL latch_edge_dropped: got %0d expected 0", snes_sysclk_freq);
                    end
                    stage = 3;
                end
                3: if (n % PERIOD == 0) begin
                    vectors++;
                    if (snes_sysclk_freq !== 32'd0) begin
                        miscompares++;
                        $display("FAIL latch_edge_next: got %0d expected 0", snes_sysclk_freq);
                    end
                    stage = 4;
                end
                default: ;
            endcase
        end
        vectors++;
        if (stage != 4) begin
            miscompares++;
            $display("FAIL latch_edge_timeout: reached stage %0d expected 4", stage);
        end
        sysclk = 1'b0;
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        half = 2;
        ph   = 0;
        drive_periodic();
        for (int i = 0; i < 100 && n != PERIOD + 9; i++) begin
            @(negedge clk);
            vectors++;
            if (snes_sysclk_freq !== exp_freq) begin
                miscompares++;
                $display("FAIL reset_mid_model: n=%0d got %h expected %h", n, snes_sysclk_freq, exp_freq);
            end
            if (n != PERIOD + 9) drive_periodic();
        end
        vectors++;
        if (snes_sysclk_freq === 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL reset_mid_before: got %h expected a measured value", snes_sysclk_freq);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (snes_sysclk_freq !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL reset_mid_immediate: got %h expected ffffffff", snes_sysclk_freq);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_periodic();
        for (int i = 1; i <= PERIOD; i++) begin
            @(negedge clk);
            vectors++;
            if (i < PERIOD) begin
                if (snes_sysclk_freq !== 32'hFFFF_FFFF) begin
                    miscompares++;
                    $display("FAIL reset_mid_early: cycle %0d got %h expected ffffffff", i, snes_sysclk_freq);
                end
            end else begin
                if (snes_sysclk_freq === 32'hFFFF_FFFF || snes_sysclk_freq !== exp_freq) begin
                    miscompares++;
                    $display("FAIL reset_mid_result: got %h expected %h", snes_sysclk_freq, exp_freq);
                end
            end
            drive_periodic();
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        repeat (6 * PERIOD) begin
            @(negedge clk);
            vectors++;
            if (snes_sysclk_freq !== exp_freq) begin
                miscompares++;
                $display("FAIL random_model: n=%0d got %h expected %h", n, snes_sysclk_freq, exp_freq);
            end
            if (n % PERIOD == 0) begin
                vectors++;
                if (snes_sysclk_freq > 32'(W / 2)) begin
                    miscompares++;
                    $display("FAIL random_bound: got %0d expected at most %0d", snes_sysclk_freq, W / 2);
                end
            end
            if (hold == 0) begin
                sysclk = ~sysclk;
                hold   = $urandom_range(5, 1);
            end
            hold--;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        sysclk      = 1'b0;
        ph          = 0;
        half        = 2;
        test_reset();
        test_period4();
        test_stopped();
        test_switch();
        test_latch_edge();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clk_test.md
CLK_TEST -- requirements
Module: clk_test

Interface
REQ-001 Parameter WINDOW_CYCLES, default 96000000, SHALL set the measurement gate length in clk cycles (nominal 1 s at 96 MHz).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the number of synchronizer flops on sysclk (minimum 2).
REQ-003 clk  input  1  SHALL be the system clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 sysclk  input  1  SHALL be the asynchronous SNES system clock to be measured.
REQ-006 snes_sysclk_freq  output  32  SHALL be the sysclk rising-edge count from the last completed window (Hz when the window is 1 s).

Function
REQ-007 sysclk SHALL pass through a SYNC_STAGES-deep flop chain clocked by clk; no combinational use of raw sysclk.
REQ-008 A rising-edge strobe SHALL be true for exactly one clk cycle when the last two chain stages read old=0, new=1.
REQ-009 The block SHALL hold a 32-bit gate counter (gate_cnt) and a 32-bit edge accumulator (edge_cnt), plus a 32-bit output register driving snes_sysclk_freq.
REQ-010 Count state: while gate_cnt < WINDOW_CYCLES, gate_cnt SHALL increment by 1 each clk cycle, and edge_cnt SHALL increment by 1 in cycles where the strobe is true.
REQ-011 Latch state: in the cycle where gate_cnt == WINDOW_CYCLES, the output register SHALL load edge_cnt, and gate_cnt and edge_cnt SHALL both clear to 0.
REQ-012 A strobe in the latch cycle SHALL be discarded (not counted in either window).
REQ-013 The full measurement period SHALL therefore be WINDOW_CYCLES+1 clk cycles, with counting active for WINDOW_CYCLES of them.
REQ-014 snes_sysclk_freq SHALL change only in the latch cycle (visible one clk after the latch edge) and SHALL hold its value for the rest of the period.
REQ-015 edge_cnt SHALL wrap modulo 2^32; overflow is unreachable for sysclk below clk/2.
REQ-016 A constant sysclk (stopped clock) SHALL produce 0 at the next latch.
REQ-017 sysclk frequencies at or above clk/2 are out of range; the result SHALL be undefined but bounded by WINDOW_CYCLES/2.

Reset
REQ-018 While rst=1: gate_cnt=0, edge_cnt=0, all synchronizer flops=0, and snes_sysclk_freq=32'hFFFFFFFF ("no measurement yet").
REQ-019 On rst deassertion, counting SHALL start on the first clk edge, with gate_cnt starting from 0.
REQ-020 The first valid result SHALL appear WINDOW_CYCLES+1 clk cycles after reset release.
REQ-021 Reset asserted mid-window SHALL abort the window, discard the partial count, and return the output to 32'hFFFFFFFF.

Verification (WINDOW_CYCLES=16, SYNC_STAGES=2)
REQ-022 Assert rst, then release -> snes_sysclk_freq=32'hFFFFFFFF until the 17th clk after release, then a measured value.
REQ-023 sysclk toggles every 2 clk (period 4 clk) -> every latch yields 4, stable across consecutive windows.
REQ-024 sysclk held at 0 for a whole window -> output 0 after the next latch.
REQ-025 sysclk period 8 clk -> output 2; then switch to period 4 mid-window -> that window gives 2 or 3, and the following window gives 4.
REQ-026 Pulse rst during gate_cnt=9 -> output returns to 32'hFFFFFFFF immediately, and the next result appears 17 clk after release.
REQ-027 A single rising edge timed to reach the strobe exactly in the latch cycle -> not counted; the next window's result excludes it.
